// File: rtl/s_edge_det.sv
// rtl/s_edge_det.sv - switch synchronizer with rising-edge pulse output
// Optional debounce filter: define S_EDGE_DET_DEBOUNCE_EN to build it in.
module s_edge_det #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sw0,
    output logic o_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   lvl;
    logic                   filt;
    logic                   prev_q;
    logic                   prev_d;
    logic                   out_q;
    logic                   out_d;

    // Shift the raw switch level into the clock domain; newest sample at bit 0
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_sw0};
    end

    // Synchronizer chain register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign lvl = sync_q[SYNC_STAGES-1];

`ifdef S_EDGE_DET_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             filt_q;
    logic             filt_d;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Filtered level only follows lvl after DEBOUNCE_CYCLES consecutive disagreements
    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (lvl == filt_q) begin
            cnt_d = '0;
        end else if (cnt_inc == CNT_W'(DEBOUNCE_CYCLES)) begin
            filt_d = lvl;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_inc;
        end
    end

    // Debounce counter and filtered level registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filt = filt_q;
`else
    logic [31:0] unused_debounce_cfg;

    assign unused_debounce_cfg = 32'(DEBOUNCE_CYCLES);
    assign filt                = lvl;
`endif

    // Pulse when the filtered level is high now but was low last cycle
    always_comb begin
        prev_d = filt;
        out_d  = filt & ~prev_q;
    end

    // Edge-detect history and registered output pulse
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            prev_q <= 1'b0;
            out_q  <= 1'b0;
        end else begin
            prev_q <= prev_d;
            out_q  <= out_d;
        end
    end

    assign o_out = out_q;

endmodule

// File: tb/tb_s_edge_det.sv
// tb/tb_s_edge_det.sv - scoreboard bench for s_edge_det
module tb_s_edge_det;

    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;
`ifdef S_EDGE_DET_DEBOUNCE_EN
    localparam int LAT = SYNC_STAGES + DEBOUNCE_CYCLES;
`else
    localparam int LAT = SYNC_STAGES;
`endif

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    logic i_sw0 = 1'b0;
    logic o_out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int exp_q[$];

    s_edge_det #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_sw0(i_sw0),
        .o_out(o_out)
    );

    always #10 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (i_rst) begin
            checks++;
            if (o_out !== 1'b0) begin
                failures++;
                $display("FAIL reset_quiet: o_out=%b required 0 at cyc %0d", o_out, cyc);
            end
        end else if (o_out === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse: pulse at cyc %0d, required none", cyc);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (cyc != e) begin
                    failures++;
                    $display("FAIL pulse_cycle: pulse at cyc %0d required cyc %0d", cyc, e);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic rise_expect();
        @(negedge i_clk);
        i_sw0 = 1'b1;
        exp_q.push_back(cyc + 1 + LAT);
    endtask

    task automatic check_now(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: o_out=%b required %b", name, act, req);
        end
    endtask

    initial begin
        // Reset held 100 ns with the switch toggling
        repeat (6) begin
            #15 i_sw0 = ~i_sw0;
        end
        i_sw0 = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
        wait_cyc(5);

        // Single edge held 100 ns
        rise_expect();
        wait_cyc(5);
        i_sw0 = 1'b0;
        wait_cyc(20);

        // Long hold then long release: one pulse only
        rise_expect();
        wait_cyc(25);
        i_sw0 = 1'b0;
        wait_cyc(25);

        // Sub-period glitch between clock edges
        @(negedge i_clk);
        #2 i_sw0 = 1'b1;
        #5 i_sw0 = 1'b0;
        wait_cyc(20);

`ifdef S_EDGE_DET_DEBOUNCE_EN
        // 30 ns pulse is seen on at most two edges and must be filtered out
        @(negedge i_clk);
        #2 i_sw0 = 1'b1;
        #30 i_sw0 = 1'b0;
        wait_cyc(20);
`endif

        // Two separated presses give two pulses
        rise_expect();
        wait_cyc(8);
        i_sw0 = 1'b0;
        wait_cyc(7);
        rise_expect();
        wait_cyc(8);
        i_sw0 = 1'b0;
        wait_cyc(25);

        // Asynchronous reset during a pulse, then re-detect with switch still high
        @(negedge i_clk);
        i_sw0 = 1'b1;
        repeat (1 + LAT) @(posedge i_clk);
        #5;
        check_now("pulse_before_async_rst", o_out, 1'b1);
        i_rst = 1'b1;
        #1;
        check_now("async_rst_clear", o_out, 1'b0);
        @(negedge i_clk);
        i_rst = 1'b0;
        exp_q.push_back(cyc + 1 + LAT);
        wait_cyc(15);
        i_sw0 = 1'b0;
        wait_cyc(30);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_pulses: %0d outstanding, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
